ptw_arbiter: RTL and testbench

- Shares the single hardware page walker (HPW) between the instruction TLB and the data TLB.
- Accepts miss requests (VPN plus access type) from both TLBs and grants one at a time.
- Gates walk launch on load/store unit memory-port activity and routes the walker response back to the owning TLB.
- Handles pipeline flush (kills instruction-side walks) and sfence quiescing, and sits between both TLBs and the HPW.

---
 rtl/ptw_arbiter_if.sv | 48 ++++
 rtl/ptw_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ptw_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ptw_arbiter_if.sv
// Bundle between the page-walk arbiter, the two TLB miss ports and the HPW.
// The master modport is the arbiter side; slave is the TLB/HPW side.
interface ptw_arbiter_if;
  logic        itlb_req_i;
  logic [19:0] itlb_vpn_i;
  logic        itlb_ack_o;
  logic        itlb_resp_vld_o;

  logic        dtlb_req_i;
  logic [19:0] dtlb_vpn_i;
  logic        dtlb_store_i;
  logic        dtlb_ack_o;
  logic        dtlb_resp_vld_o;

  logic [31:0] resp_pte_o;
  logic        resp_superpage_o;
  logic [3:0]  resp_excp_code_o;
  logic        resp_excp_vld_o;

  logic        walk_vld_o;
  logic [19:0] walk_vpn_o;
  logic        walk_store_o;
  logic        walk_instr_o;
  logic        walk_rdy_i;
  logic        walk_resp_vld_i;
  logic [31:0] walk_pte_i;
  logic        walk_superpage_i;
  logic [3:0]  walk_excp_code_i;
  logic        walk_excp_vld_i;

  modport master (
    input  itlb_req_i, itlb_vpn_i, dtlb_req_i, dtlb_vpn_i, dtlb_store_i,
    input  walk_rdy_i, walk_resp_vld_i, walk_pte_i, walk_superpage_i,
    input  walk_excp_code_i, walk_excp_vld_i,
    output itlb_ack_o, itlb_resp_vld_o, dtlb_ack_o, dtlb_resp_vld_o,
    output resp_pte_o, resp_superpage_o, resp_excp_code_o, resp_excp_vld_o,
    output walk_vld_o, walk_vpn_o, walk_store_o, walk_instr_o
  );

  modport slave (
    output itlb_req_i, itlb_vpn_i, dtlb_req_i, dtlb_vpn_i, dtlb_store_i,
    output walk_rdy_i, walk_resp_vld_i, walk_pte_i, walk_superpage_i,
    output walk_excp_code_i, walk_excp_vld_i,
    input  itlb_ack_o, itlb_resp_vld_o, dtlb_ack_o, dtlb_resp_vld_o,
    input  resp_pte_o, resp_superpage_o, resp_excp_code_o, resp_excp_vld_o,
    input  walk_vld_o, walk_vpn_o, walk_store_o, walk_instr_o
  );
endinterface

// File: rtl/ptw_arbiter.sv
// Shares one hardware page walker between ITLB and DTLB, one walk in flight.
// PTW_ARB_ROUND_ROBIN_EN: alternate winners instead of DTLB priority + streak limit.
module ptw_arbiter #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic         cpu_clk_i,
  input  logic         cpu_rst_i,
  input  logic         flush_i,
  input  logic         sfence_i,
  input  logic         busy_i,
  output logic         sfence_safe_o,
  ptw_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_reg, state_next;
  logic        owner_itlb_reg;
  logic [19:0] vpn_reg;
  logic        store_reg;
  logic        walk_vld_reg, walk_vld_next;
  logic        killed_reg, killed_next;
  logic        itlb_ack_reg, dtlb_ack_reg;
  logic        itlb_resp_reg, dtlb_resp_reg;
  logic [31:0] pte_reg;
  logic        superpage_reg;
  logic [3:0]  excp_code_reg;
  logic        excp_vld_reg;
  logic        sfence_safe_reg;

  logic itlb_elig, any_req, pick_itlb;
  logic grant_itlb, grant_dtlb;
  logic capture, pulse_itlb, pulse_dtlb;
  logic itlb_flushed;

  assign itlb_elig    = bus.itlb_req_i & ~flush_i;
  assign any_req      = itlb_elig | bus.dtlb_req_i;
  assign itlb_flushed = owner_itlb_reg & flush_i;

`ifdef PTW_ARB_ROUND_ROBIN_EN
  logic last_itlb_reg;

  // Reset value marks ITLB as last owner so DTLB wins the first contest.
  assign pick_itlb = itlb_elig & (~bus.dtlb_req_i | ~last_itlb_reg);

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i)
      last_itlb_reg <= 1'b1;
    else if (grant_itlb | grant_dtlb)
      last_itlb_reg <= grant_itlb;
  end
`else
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  logic [3:0] streak_reg;

  assign pick_itlb = itlb_elig & (~bus.dtlb_req_i | (streak_reg >= STREAK_MAX));

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i)
      streak_reg <= 4'd0;
    else if (!bus.itlb_req_i || grant_itlb)
      streak_reg <= 4'd0;
    else if (grant_dtlb && (streak_reg < STREAK_MAX))
      streak_reg <= streak_reg + 4'd1;
  end
`endif

  always_comb begin
    state_next    = state_reg;
    walk_vld_next = walk_vld_reg;
    killed_next   = killed_reg;
    grant_itlb    = 1'b0;
    grant_dtlb    = 1'b0;
    capture       = 1'b0;
    pulse_itlb    = 1'b0;
    pulse_dtlb    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!sfence_i && !busy_i && any_req) begin
          grant_itlb = pick_itlb;
          grant_dtlb = ~pick_itlb;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (itlb_flushed) begin
          walk_vld_next = 1'b0;
          // HPW already took the request: let it finish but swallow the result.
          if (walk_vld_reg && bus.walk_rdy_i) begin
            killed_next = 1'b1;
            state_next  = WAIT;
          end else begin
            state_next = IDLE;
          end
        end else if (walk_vld_reg && bus.walk_rdy_i) begin
          walk_vld_next = 1'b0;
          state_next    = WAIT;
        end else begin
          walk_vld_next = 1'b1;
        end
      end
      WAIT: begin
        if (bus.walk_resp_vld_i) begin
          state_next  = IDLE;
          killed_next = 1'b0;
          if (!killed_reg && !itlb_flushed) begin
            capture    = 1'b1;
            pulse_itlb = owner_itlb_reg;
            pulse_dtlb = ~owner_itlb_reg;
          end
        end else if (itlb_flushed) begin
          killed_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      state_reg       <= IDLE;
      owner_itlb_reg  <= 1'b0;
      vpn_reg         <= 20'd0;
      store_reg       <= 1'b0;
      walk_vld_reg    <= 1'b0;
      killed_reg      <= 1'b0;
      itlb_ack_reg    <= 1'b0;
      dtlb_ack_reg    <= 1'b0;
      itlb_resp_reg   <= 1'b0;
      dtlb_resp_reg   <= 1'b0;
      pte_reg         <= 32'd0;
      superpage_reg   <= 1'b0;
      excp_code_reg   <= 4'd0;
      excp_vld_reg    <= 1'b0;
      sfence_safe_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      walk_vld_reg    <= walk_vld_next;
      killed_reg      <= killed_next;
      itlb_ack_reg    <= grant_itlb;
      dtlb_ack_reg    <= grant_dtlb;
      itlb_resp_reg   <= pulse_itlb;
      dtlb_resp_reg   <= pulse_dtlb;
      sfence_safe_reg <= (state_next == IDLE);
      if (grant_itlb || grant_dtlb) begin
        owner_itlb_reg <= grant_itlb;
        vpn_reg        <= grant_itlb ? bus.itlb_vpn_i : bus.dtlb_vpn_i;
        store_reg      <= grant_dtlb & bus.dtlb_store_i;
      end
      if (capture) begin
        pte_reg       <= bus.walk_pte_i;
        superpage_reg <= bus.walk_superpage_i;
        excp_code_reg <= bus.walk_excp_code_i;
        excp_vld_reg  <= bus.walk_excp_vld_i;
      end
    end
  end

  assign bus.itlb_ack_o       = itlb_ack_reg;
  assign bus.dtlb_ack_o       = dtlb_ack_reg;
  assign bus.itlb_resp_vld_o  = itlb_resp_reg;
  assign bus.dtlb_resp_vld_o  = dtlb_resp_reg;
  assign bus.resp_pte_o       = pte_reg;
  assign bus.resp_superpage_o = superpage_reg;
  assign bus.resp_excp_code_o = excp_code_reg;
  assign bus.resp_excp_vld_o  = excp_vld_reg;
  assign bus.walk_vld_o       = walk_vld_reg;
  assign bus.walk_vpn_o       = vpn_reg;
  assign bus.walk_store_o     = store_reg;
  assign bus.walk_instr_o     = owner_itlb_reg;
  assign sfence_safe_o        = sfence_safe_reg;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: one task per scenario, inline checks,
// with a small HPW responder process and a pulse monitor.
`timescale 1ns/1ps
module tb_ptw_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, sfence = 1'b0, busy = 1'b0;
  logic safe;
  int   total = 0, passed = 0;

  always #5 clk = ~clk;

  ptw_arbiter_if bus ();

  ptw_arbiter #(.MAX_STREAK(4)) dut (
    .cpu_clk_i    (clk),
    .cpu_rst_i    (rst),
    .flush_i      (flush),
    .sfence_i     (sfence),
    .busy_i       (busy),
    .sfence_safe_o(safe),
    .bus          (bus)
  );

  // Pulse monitor, sampled mid-cycle
  int n_iack = 0, n_dack = 0, n_iresp = 0, n_dresp = 0, n_wvld = 0;
  int glog[$];
  always @(negedge clk) begin
    if (bus.itlb_ack_o === 1'b1) begin n_iack++; glog.push_back(1); end
    if (bus.dtlb_ack_o === 1'b1) begin n_dack++; glog.push_back(0); end
    if (bus.itlb_resp_vld_o === 1'b1) n_iresp++;
    if (bus.dtlb_resp_vld_o === 1'b1) n_dresp++;
    if (bus.walk_vld_o === 1'b1) n_wvld++;
  end

  // HPW responder: auto mode answers hpw_delay cycles after acceptance; kick forces one pulse
  bit hpw_auto = 1'b1;
  int hpw_delay = 3;
  int kick_req = 0;
  initial begin
    int cnt;
    int kick_seen;
    bit accept;
    cnt = 0;
    kick_seen = 0;
    bus.walk_resp_vld_i = 1'b0;
    forever begin
      @(posedge clk);
      accept = (bus.walk_vld_o === 1'b1) && (bus.walk_rdy_i === 1'b1);
      #1;
      bus.walk_resp_vld_i = 1'b0;
      if (kick_req != kick_seen) begin
        kick_seen = kick_req;
        bus.walk_resp_vld_i = 1'b1;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) bus.walk_resp_vld_i = 1'b1;
      end
      if (accept && hpw_auto) cnt = hpw_delay;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_safe();
    for (int i = 0; i < 40 && safe !== 1'b1; i++) tick();
    total++; if (safe !== 1'b1) $display("FAIL wait_safe: sfence_safe_o=%b want 1", safe); else passed++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++; if (safe !== 1'b1) $display("FAIL rst_safe: got %b want 1", safe); else passed++;
    total++; if (bus.walk_vld_o !== 1'b0) $display("FAIL rst_walk_vld: got %b want 0", bus.walk_vld_o); else passed++;
    total++; if ({bus.itlb_ack_o, bus.dtlb_ack_o, bus.itlb_resp_vld_o, bus.dtlb_resp_vld_o} !== 4'b0) $display("FAIL rst_pulses: got %b want 0000", {bus.itlb_ack_o, bus.dtlb_ack_o, bus.itlb_resp_vld_o, bus.dtlb_resp_vld_o}); else passed++;
    total++; if (bus.resp_pte_o !== 32'd0) $display("FAIL rst_pte: got %h want 0", bus.resp_pte_o); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lone_dtlb();
    int bd, bi;
    bus.dtlb_vpn_i = 20'h12345; bus.dtlb_store_i = 1'b1;
    bus.walk_pte_i = 32'h2000_0C1F; bus.walk_superpage_i = 1'b0;
    bus.walk_excp_code_i = 4'd0; bus.walk_excp_vld_i = 1'b0;
    hpw_auto = 1'b1;
    bd = n_dresp; bi = n_iresp + n_iack;
    bus.dtlb_req_i = 1'b1;
    tick();
    total++; if (bus.dtlb_ack_o !== 1'b1) $display("FAIL lone_ack: got %b want 1", bus.dtlb_ack_o); else passed++;
    total++; if (bus.walk_vld_o !== 1'b0) $display("FAIL lone_vld_early: got %b want 0", bus.walk_vld_o); else passed++;
    bus.dtlb_req_i = 1'b0;
    tick();
    total++; if (bus.walk_vld_o !== 1'b1 || bus.walk_store_o !== 1'b1 || bus.walk_instr_o !== 1'b0) $display("FAIL lone_walk: vld/store/instr=%b%b%b want 110", bus.walk_vld_o, bus.walk_store_o, bus.walk_instr_o); else passed++;
    total++; if (bus.walk_vpn_o !== 20'h12345) $display("FAIL lone_vpn: got %h want 12345", bus.walk_vpn_o); else passed++;
    total++; if (bus.dtlb_ack_o !== 1'b0) $display("FAIL lone_ack_width: got %b want 0", bus.dtlb_ack_o); else passed++;
    for (int i = 0; i < 12 && bus.dtlb_resp_vld_o !== 1'b1; i++) tick();
    total++; if (bus.dtlb_resp_vld_o !== 1'b1) $display("FAIL lone_resp: dtlb_resp_vld_o=%b want 1", bus.dtlb_resp_vld_o); else passed++;
    total++; if (bus.resp_pte_o !== 32'h2000_0C1F) $display("FAIL lone_pte: got %h want 20000c1f", bus.resp_pte_o); else passed++;
    repeat (2) tick();
    total++; if (n_dresp - bd != 1) $display("FAIL lone_resp_count: got %0d want 1", n_dresp - bd); else passed++;
    total++; if (n_iresp + n_iack - bi != 0) $display("FAIL lone_itlb_quiet: got %0d itlb pulses want 0", n_iresp + n_iack - bi); else passed++;
    total++; if (safe !== 1'b1) $display("FAIL lone_safe: got %b want 1", safe); else passed++;
  endtask

  task automatic test_streak();
    int base, got;
    int exp_order [10];
`ifdef PTW_ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    base = glog.size();
    bus.itlb_vpn_i = 20'h11111; bus.dtlb_vpn_i = 20'h22222; bus.dtlb_store_i = 1'b0;
    bus.itlb_req_i = 1'b1; bus.dtlb_req_i = 1'b1;
    for (int i = 0; i < 600 && glog.size() - base < 10; i++) tick();
    bus.itlb_req_i = 1'b0; bus.dtlb_req_i = 1'b0;
    total++; if (glog.size() - base < 10) $display("FAIL streak_timeout: got %0d grants want 10", glog.size() - base); else passed++;
    for (int k = 0; k < 10; k++) begin
      got = (base + k < glog.size()) ? glog[base + k] : -1;
      total++; if (got != exp_order[k]) $display("FAIL streak_order[%0d]: got %0d want %0d (1=ITLB)", k, got, exp_order[k]); else passed++;
    end
    wait_safe();
  endtask

  task automatic test_busy();
    int ba, bv;
    ba = n_iack + n_dack; bv = n_wvld;
    busy = 1'b1;
    bus.itlb_vpn_i = 20'h00ABC;
    bus.itlb_req_i = 1'b1;
    repeat (5) tick();
    total++; if (n_iack + n_dack - ba != 0) $display("FAIL busy_ack: got %0d acks want 0", n_iack + n_dack - ba); else passed++;
    total++; if (n_wvld - bv != 0) $display("FAIL busy_walk: got %0d walk_vld cycles want 0", n_wvld - bv); else passed++;
    busy = 1'b0;
    tick();
    total++; if (bus.itlb_ack_o !== 1'b1) $display("FAIL busy_release_ack: got %b want 1", bus.itlb_ack_o); else passed++;
    total++; if (bus.walk_vpn_o !== 20'h00ABC || bus.walk_instr_o !== 1'b1) $display("FAIL busy_vpn: vpn=%h instr=%b want 00abc/1", bus.walk_vpn_o, bus.walk_instr_o); else passed++;
    bus.itlb_req_i = 1'b0;
    for (int i = 0; i < 12 && bus.itlb_resp_vld_o !== 1'b1; i++) tick();
    total++; if (bus.itlb_resp_vld_o !== 1'b1) $display("FAIL busy_resp: itlb_resp_vld_o=%b want 1", bus.itlb_resp_vld_o); else passed++;
    wait_safe();
  endtask

  task automatic test_flush();
    int bi;
    hpw_auto = 1'b0;
    bi = n_iresp;
    bus.itlb_vpn_i = 20'h0AAAA;
    bus.itlb_req_i = 1'b1;
    for (int i = 0; i < 10 && bus.itlb_ack_o !== 1'b1; i++) tick();
    total++; if (bus.itlb_ack_o !== 1'b1) $display("FAIL flush_ack: got %b want 1", bus.itlb_ack_o); else passed++;
    bus.itlb_req_i = 1'b0;
    for (int i = 0; i < 10 && bus.walk_vld_o !== 1'b1; i++) tick();
    tick();
    total++; if (safe !== 1'b0 || bus.walk_vld_o !== 1'b0) $display("FAIL flush_in_wait: safe=%b vld=%b want 0/0", safe, bus.walk_vld_o); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.walk_pte_i = 32'hDEAD_BEEF; bus.walk_excp_vld_i = 1'b1; bus.walk_excp_code_i = 4'd12;
    kick_req++;
    repeat (4) tick();
    total++; if (n_iresp - bi != 0) $display("FAIL flush_no_resp: got %0d pulses want 0", n_iresp - bi); else passed++;
    total++; if (bus.resp_pte_o !== 32'h2000_0C1F) $display("FAIL flush_pte_kept: got %h want 20000c1f", bus.resp_pte_o); else passed++;
    total++; if (bus.resp_excp_vld_o !== 1'b0 || bus.resp_excp_code_o !== 4'd0) $display("FAIL flush_excp_kept: got %b/%0d want 0/0", bus.resp_excp_vld_o, bus.resp_excp_code_o); else passed++;
    total++; if (safe !== 1'b1) $display("FAIL flush_safe: got %b want 1", safe); else passed++;
    // A DTLB walk afterwards proceeds normally
    bus.walk_pte_i = 32'h1234_5678; bus.walk_excp_vld_i = 1'b0; bus.walk_excp_code_i = 4'd0;
    hpw_auto = 1'b1;
    bus.dtlb_vpn_i = 20'h33333;
    bus.dtlb_req_i = 1'b1;
    for (int i = 0; i < 10 && bus.dtlb_ack_o !== 1'b1; i++) tick();
    total++; if (bus.dtlb_ack_o !== 1'b1) $display("FAIL flush_next_ack: got %b want 1", bus.dtlb_ack_o); else passed++;
    bus.dtlb_req_i = 1'b0;
    for (int i = 0; i < 12 && bus.dtlb_resp_vld_o !== 1'b1; i++) tick();
    total++; if (bus.dtlb_resp_vld_o !== 1'b1 || bus.resp_pte_o !== 32'h1234_5678) $display("FAIL flush_next_resp: vld=%b pte=%h want 1/12345678", bus.dtlb_resp_vld_o, bus.resp_pte_o); else passed++;
    wait_safe();
  endtask

  task automatic test_sfence();
    int ba;
    logic exp_itlb_win;
`ifdef PTW_ARB_ROUND_ROBIN_EN
    exp_itlb_win = 1'b1;
`else
    exp_itlb_win = 1'b0;
`endif
    bus.dtlb_vpn_i = 20'h44444;
    bus.dtlb_req_i = 1'b1;
    for (int i = 0; i < 10 && bus.dtlb_ack_o !== 1'b1; i++) tick();
    bus.dtlb_req_i = 1'b0;
    sfence = 1'b1;
    for (int i = 0; i < 12 && bus.dtlb_resp_vld_o !== 1'b1; i++) tick();
    total++; if (bus.dtlb_resp_vld_o !== 1'b1) $display("FAIL sfence_walk_done: got %b want 1", bus.dtlb_resp_vld_o); else passed++;
    tick();
    ba = n_iack + n_dack;
    bus.itlb_req_i = 1'b1; bus.dtlb_req_i = 1'b1;
    repeat (8) tick();
    total++; if (n_iack + n_dack - ba != 0) $display("FAIL sfence_block: got %0d grants want 0", n_iack + n_dack - ba); else passed++;
    total++; if (safe !== 1'b1) $display("FAIL sfence_safe: got %b want 1", safe); else passed++;
    sfence = 1'b0;
    for (int i = 0; i < 10 && bus.itlb_ack_o !== 1'b1 && bus.dtlb_ack_o !== 1'b1; i++) tick();
    total++; if (bus.itlb_ack_o !== exp_itlb_win || bus.dtlb_ack_o !== ~exp_itlb_win) $display("FAIL sfence_release: i/d ack=%b%b want %b%b", bus.itlb_ack_o, bus.dtlb_ack_o, exp_itlb_win, ~exp_itlb_win); else passed++;
    bus.itlb_req_i = 1'b0; bus.dtlb_req_i = 1'b0;
    wait_safe();
  endtask

  task automatic test_reset_in_wait();
    int bi, bd;
    hpw_auto = 1'b0;
    bus.walk_pte_i = 32'h0BAD_0001;
    bus.dtlb_vpn_i = 20'h55555;
    bus.dtlb_req_i = 1'b1;
    for (int i = 0; i < 10 && bus.dtlb_ack_o !== 1'b1; i++) tick();
    bus.dtlb_req_i = 1'b0;
    for (int i = 0; i < 10 && bus.walk_vld_o !== 1'b1; i++) tick();
    tick();
    total++; if (safe !== 1'b0) $display("FAIL rstw_in_wait: safe=%b want 0", safe); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (safe !== 1'b1) $display("FAIL rstw_safe: got %b want 1", safe); else passed++;
    total++; if (bus.resp_pte_o !== 32'd0 || bus.walk_vpn_o !== 20'd0) $display("FAIL rstw_regs: pte=%h vpn=%h want 0/0", bus.resp_pte_o, bus.walk_vpn_o); else passed++;
    tick();
    rst = 1'b0;
    bi = n_iresp; bd = n_dresp;
    kick_req++;
    repeat (4) tick();
    total++; if (n_iresp + n_dresp - bi - bd != 0) $display("FAIL rstw_stale: got %0d resp pulses want 0", n_iresp + n_dresp - bi - bd); else passed++;
    total++; if (bus.resp_pte_o !== 32'd0) $display("FAIL rstw_stale_pte: got %h want 0", bus.resp_pte_o); else passed++;
  endtask

  initial begin
    bus.itlb_req_i = 1'b0; bus.itlb_vpn_i = 20'd0;
    bus.dtlb_req_i = 1'b0; bus.dtlb_vpn_i = 20'd0; bus.dtlb_store_i = 1'b0;
    bus.walk_rdy_i = 1'b1;
    bus.walk_pte_i = 32'd0; bus.walk_superpage_i = 1'b0;
    bus.walk_excp_code_i = 4'd0; bus.walk_excp_vld_i = 1'b0;
    test_reset();
    test_lone_dtlb();
    test_streak();
    test_busy();
    test_flush();
    test_sfence();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end
endmodule
